// File: rtl/spi_xfer_scheduler_if.sv
// Request/grant bundle between the APB-side channel logic and the SPI transfer scheduler.
// The master modport is the scheduler side. The slave modport is the requester/datapath side.
interface spi_xfer_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic               mstr_i;
  logic               spiswai_i;
  logic [NUM_REQ-1:0] req_i;
  logic               tip_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic [ID_W-1:0]    gnt_id_o;
  logic               send_data_o;
  logic               busy_o;
  logic               done_o;
  logic               err_o;

  modport master (
    input  mstr_i, spiswai_i, req_i, tip_i,
    output gnt_o, gnt_id_o, send_data_o, busy_o, done_o, err_o
  );

  modport slave (
    output mstr_i, spiswai_i, req_i, tip_i,
    input  gnt_o, gnt_id_o, send_data_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/spi_xfer_scheduler.sv
// Round-robin scheduler sharing one SPI shifter/slave-select path between NUM_REQ requesters.
// It launches a transfer, tracks tip, enforces an idle gap and aborts when tip never rises.
module spi_xfer_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned TIP_TIMEOUT = 16
) (
  input logic                  pclk,
  input logic                  preset,
  spi_xfer_scheduler_if.master bus
);

  localparam int unsigned TMO_W = (TIP_TIMEOUT > 2) ? $clog2(TIP_TIMEOUT) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    WAIT_TIP = 3'd2,
    ACTIVE   = 3'd3,
    GAP      = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               send_q, send_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic [ID_W-1:0]    winner;
  logic               found;
  logic [ID_W-1:0]    ptr_next;

  // Round-robin search: first set request at ptr, ptr+1, ... wrapping at NUM_REQ-1.
  always_comb begin
    logic [ID_W-1:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      idx = ID_W'((int'(ptr_q) + i) % int'(NUM_REQ));
      if (!found && bus.req_i[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign ptr_next = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    send_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ptr_d    = ptr_q;
    tmo_d    = tmo_q;
    gap_d    = gap_q;

    case (state_q)
      IDLE: begin
        if (bus.mstr_i && !bus.spiswai_i && found) begin
          state_d  = LAUNCH;
          gnt_d    = NUM_REQ'(1) << winner;
          gnt_id_d = winner;
          busy_d   = 1'b1;
          send_d   = 1'b1;
        end
      end

      LAUNCH: begin
        state_d = WAIT_TIP;
        tmo_d   = '0;
      end

      // tip wins over the terminal count when both happen on the same cycle.
      WAIT_TIP: begin
        if (bus.tip_i) begin
          state_d = ACTIVE;
        end else if (tmo_q == TMO_W'(TIP_TIMEOUT - 2)) begin
          state_d = GAP;
          done_d  = 1'b1;
          err_d   = 1'b1;
          gnt_d   = '0;
          ptr_d   = ptr_next;
          gap_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ACTIVE: begin
        if (!bus.tip_i) begin
          state_d = GAP;
          done_d  = 1'b1;
          gnt_d   = '0;
          ptr_d   = ptr_next;
          gap_d   = '0;
        end
      end

      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      send_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ptr_q    <= '0;
      tmo_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      send_q   <= send_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ptr_q    <= ptr_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_id_o    = gnt_id_q;
  assign bus.send_data_o = send_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Directed bench for spi_xfer_scheduler: hand-computed expectations checked with immediate assertions.
module tb_spi_xfer_scheduler;

  logic pclk = 1'b0;
  logic preset;
  int   checks   = 0;
  int   failures = 0;

  spi_xfer_scheduler_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  spi_xfer_scheduler #(
    .NUM_REQ(4), .ID_W(2), .GAP_CYCLES(2), .TIP_TIMEOUT(16)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"},  32'(bus.gnt_o), 32'h0);
    check({tag, "_send"}, 32'(bus.send_data_o), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy_o), 32'h0);
    check({tag, "_done"}, 32'(bus.done_o), 32'h0);
    check({tag, "_err"},  32'(bus.err_o), 32'h0);
  endtask

  initial begin
    preset        = 1'b1;
    bus.mstr_i    = 1'b0;
    bus.spiswai_i = 1'b0;
    bus.req_i     = 4'b0000;
    bus.tip_i     = 1'b0;
    tick(2);
    preset = 1'b0;
    check_idle_outputs("reset");
    check("reset_id", 32'(bus.gnt_id_o), 32'h0);

    // Single transfer from requester 0.
    bus.mstr_i = 1'b1;
    bus.req_i  = 4'b0001;
    tick(1);
    check("t1_gnt",  32'(bus.gnt_o), 32'h1);
    check("t1_send", 32'(bus.send_data_o), 32'h1);
    check("t1_busy", 32'(bus.busy_o), 32'h1);
    bus.req_i = 4'b0000;
    tick(1);
    check("t1_send_drop", 32'(bus.send_data_o), 32'h0);
    tick(2);
    bus.tip_i = 1'b1;
    tick(20);
    check("t1_active_gnt",  32'(bus.gnt_o), 32'h1);
    check("t1_active_done", 32'(bus.done_o), 32'h0);
    bus.tip_i = 1'b0;
    tick(1);
    check("t1_done", 32'(bus.done_o), 32'h1);
    check("t1_err",  32'(bus.err_o), 32'h0);
    check("t1_gnt_clr", 32'(bus.gnt_o), 32'h0);
    check("t1_gap_busy", 32'(bus.busy_o), 32'h1);
    tick(1);
    check("t1_done_pulse", 32'(bus.done_o), 32'h0);
    check("t1_gap_busy2", 32'(bus.busy_o), 32'h1);
    tick(1);
    check("t1_idle_busy", 32'(bus.busy_o), 32'h0);
    check("t1_id_hold", 32'(bus.gnt_id_o), 32'h0);

    // All four requesting: round robin 0,1,2,3,0 from a fresh pointer.
    preset = 1'b1;
    tick(1);
    preset    = 1'b0;
    bus.req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check($sformatf("rr%0d_id", k),   32'(bus.gnt_id_o), 32'(k % 4));
      check($sformatf("rr%0d_gnt", k),  32'(bus.gnt_o), 32'(1 << (k % 4)));
      check($sformatf("rr%0d_send", k), 32'(bus.send_data_o), 32'h1);
      tick(1);
      bus.tip_i = 1'b1;
      check($sformatf("rr%0d_send_once", k), 32'(bus.send_data_o), 32'h0);
      tick(1);
      bus.tip_i = 1'b0;
      tick(1);
      check($sformatf("rr%0d_done", k), 32'(bus.done_o), 32'h1);
      tick(1);
      check($sformatf("rr%0d_gap_send", k), 32'(bus.send_data_o), 32'h0);
      tick(1);
      check($sformatf("rr%0d_gap_busy", k), 32'(bus.busy_o), 32'h0);
    end
    bus.req_i = 4'b0000;

    // Timeout abort on requester 2 (pointer is now 1).
    bus.req_i = 4'b0100;
    tick(1);
    check("to_id",   32'(bus.gnt_id_o), 32'h2);
    check("to_send", 32'(bus.send_data_o), 32'h1);
    bus.req_i = 4'b0000;
    tick(15);
    check("to_early_done", 32'(bus.done_o), 32'h0);
    check("to_early_gnt",  32'(bus.gnt_o), 32'h4);
    tick(1);
    check("to_done", 32'(bus.done_o), 32'h1);
    check("to_err",  32'(bus.err_o), 32'h1);
    check("to_gnt",  32'(bus.gnt_o), 32'h0);
    tick(1);
    check("to_err_pulse", 32'(bus.err_o), 32'h0);
    tick(1);
    check("to_idle_busy", 32'(bus.busy_o), 32'h0);
    bus.req_i = 4'b0100;
    tick(1);
    check("to_regrant", 32'(bus.gnt_o), 32'h4);
    bus.req_i = 4'b0000;
    tick(1);
    bus.tip_i = 1'b1;
    tick(1);
    bus.tip_i = 1'b0;
    tick(3);
    check("to_regrant_idle", 32'(bus.busy_o), 32'h0);

    // Mode gating: wait mode and slave mode block new grants.
    bus.spiswai_i = 1'b1;
    bus.req_i     = 4'b0010;
    tick(3);
    check("wai_gnt",  32'(bus.gnt_o), 32'h0);
    check("wai_busy", 32'(bus.busy_o), 32'h0);
    bus.spiswai_i = 1'b0;
    bus.mstr_i    = 1'b0;
    tick(2);
    check("slv_busy", 32'(bus.busy_o), 32'h0);
    bus.mstr_i = 1'b1;
    tick(1);
    check("mode_id",  32'(bus.gnt_id_o), 32'h1);
    check("mode_gnt", 32'(bus.gnt_o), 32'h2);
    bus.mstr_i    = 1'b0;
    bus.spiswai_i = 1'b1;
    bus.req_i     = 4'b0000;
    tick(1);
    bus.tip_i = 1'b1;
    tick(1);
    check("mode_keep_busy", 32'(bus.busy_o), 32'h1);
    check("mode_keep_gnt",  32'(bus.gnt_o), 32'h2);

    // Reset during ACTIVE: silent abort, pointer back to 0.
    preset = 1'b1;
    tick(1);
    check_idle_outputs("mid_rst");
    preset    = 1'b0;
    bus.tip_i = 1'b0;
    tick(1);
    check("mid_rst_nodone", 32'(bus.done_o), 32'h0);
    bus.mstr_i    = 1'b1;
    bus.spiswai_i = 1'b0;
    bus.req_i     = 4'b1010;
    tick(1);
    check("post_rst_id", 32'(bus.gnt_id_o), 32'h1);
    check("post_rst_gnt", 32'(bus.gnt_o), 32'h2);

    // tip rising on the terminal timeout cycle wins.
    bus.req_i = 4'b0000;
    tick(1);
    tick(14);
    check("term_nodone", 32'(bus.done_o), 32'h0);
    bus.tip_i = 1'b1;
    tick(1);
    check("term_err",  32'(bus.err_o), 32'h0);
    check("term_done", 32'(bus.done_o), 32'h0);
    check("term_gnt",  32'(bus.gnt_o), 32'h2);
    tick(2);
    check("term_active", 32'(bus.done_o), 32'h0);
    bus.tip_i = 1'b0;
    tick(1);
    check("term_fall_done", 32'(bus.done_o), 32'h1);
    check("term_fall_err",  32'(bus.err_o), 32'h0);
    tick(2);
    check("term_idle", 32'(bus.busy_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
